// File: rtl/sram_arbiter_pkg.sv
// Shared widths, SRAM pin polarities and arbiter state encodings for the
// memory subsystem.
package sram_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH = 8;
  localparam int DATA_WIDTH     = 16;

  // SRAM pins: cs_ is active-low, rw_ low selects a write.
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;
  localparam logic Write    = 1'b0;
  localparam logic Read     = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win
// last time is chosen; a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o  = |req_i;
  assign winner_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port SRAM.
// Each transaction takes IDLE -> ACCESS -> DONE; the SRAM pins are registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [MEM_ADDR_WIDTH-1:0] addr0,
  input  logic [MEM_ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]     wdata0,
  input  logic [DATA_WIDTH-1:0]     wdata1,
  output logic [DATA_WIDTH-1:0]     rdata0,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic                      busy,
  output logic                      gnt_id,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mem_cs_,
  output logic                      mem_rw_
);

  arb_state_e                state_q, state_d;
  logic                      last_q, last_d;
  logic                      gnt_q, gnt_d;
  logic                      we_q, we_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      cs_q, cs_d;
  logic                      rw_q, rw_d;
  logic                      ack0_q, ack0_d;
  logic                      ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]     rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]     rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req_i    ({req1, req0}),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= Disable_;
      rw_q     <= Read;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      rw_q     <= rw_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cs_d     = Disable_;
    rw_d     = Read;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_winner;
          last_d  = pick_winner;
          we_d    = pick_winner ? we1 : we0;
          addr_d  = pick_winner ? addr1 : addr0;
          wdata_d = pick_winner ? wdata1 : wdata0;
          // Pin values for ACCESS are set up here so they leave a register.
          cs_d    = Enable_;
          rw_d    = (pick_winner ? we1 : we0) ? Write : Read;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = ARB_DONE;
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ARB_IDLE);
  assign gnt_id    = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_cs_   = cs_q;
  assign mem_rw_   = rw_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a behavioural SRAM and an ack scoreboard.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [15:0] rdata0, rdata1;
  logic        ack0, ack1, busy, gnt_id;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_cs_, mem_rw_;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs_(mem_cs_), .mem_rw_(mem_rw_)
  );

  always #5 clk = ~clk;

  // SRAM model: combinational read, write when cs_ low and rw_ low.
  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_cs_ == 1'b0 && mem_rw_ == 1'b0) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    int          port;
    bit          is_read;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          port;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_rd0 = 16'h0;
  logic [15:0] exp_rd1 = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input bit rd, input logic [15:0] d);
    sb_t e;
    e.port = p; e.is_read = rd; e.data = d;
    sb_q.push_back(e);
  endtask

  // Every wait goes through here so each ack is matched against the scoreboard.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (ack0 || ack1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port", {30'd0, ack1, ack0}, (e.port == 1) ? 32'd2 : 32'd1);
        if (e.is_read) begin
          if (e.port == 0) begin
            chk("rdata0", {16'd0, rdata0}, {16'd0, e.data});
            exp_rd0 = e.data;
          end else begin
            chk("rdata1", {16'd0, rdata1}, {16'd0, e.data});
            exp_rd1 = e.data;
          end
        end
      end
      $display("txn ack0=%0b ack1=%0b rdata0=%h rdata1=%h t=%0t", ack0, ack1, rdata0, rdata1, $time);
    end
  endtask

  task automatic drive(input int p, input bit we, input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_txn(input int p, input bit we, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
    int n;
    bit got;
    drive(p, we, a, d);
    push(p, !we, exp);
    n = 0; got = 0;
    while (!got && n < 8) begin
      tick();
      n++;
      if (n == 1) begin
        chk("access_cs", {31'd0, mem_cs_}, 32'd0);
        chk("access_rw", {31'd0, mem_rw_}, we ? 32'd0 : 32'd1);
        chk("access_addr", {24'd0, mem_addr}, {24'd0, a});
        if (we) chk("access_wdata", {16'd0, mem_wdata}, {16'd0, d});
        chk("access_gnt", {31'd0, gnt_id}, p);
      end
      got = (p == 1) ? ack1 : ack0;
    end
    chk("latency", n, 32'd2);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk("rdata0_hold", {16'd0, rdata0}, {16'd0, exp_rd0});
    chk("rdata1_hold", {16'd0, rdata1}, {16'd0, exp_rd1});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_rd0 = 16'h0;
    exp_rd1 = 16'h0;
    tick();
  endtask

  int t0, t1, n, nack;
  int at[4];

  initial begin
    vecs[0] = '{0, 1'b1, 8'h05, 16'hA5A5, 16'h0000};
    vecs[1] = '{0, 1'b0, 8'h05, 16'h0000, 16'hA5A5};
    vecs[2] = '{1, 1'b1, 8'h01, 16'h1111, 16'h0000};
    vecs[3] = '{1, 1'b1, 8'h02, 16'h2222, 16'h0000};
    vecs[4] = '{1, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
    vecs[5] = '{1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[6] = '{1, 1'b1, 8'h7F, 16'h003C, 16'h0000};
    vecs[7] = '{0, 1'b0, 8'h7F, 16'h0000, 16'h003C};

    // Reset values
    tick();
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_gnt", {31'd0, gnt_id}, 0);
    chk("rst_cs", {31'd0, mem_cs_}, 1);
    chk("rst_rw", {31'd0, mem_rw_}, 1);
    chk("rst_addr", {24'd0, mem_addr}, 0);
    chk("rst_wdata", {16'd0, mem_wdata}, 0);
    chk("rst_rdata0", {16'd0, rdata0}, 0);
    chk("rst_rdata1", {16'd0, rdata1}, 0);
    rst = 1'b0;
    tick();

    // Single-port transactions from the table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // Simultaneous requests straight out of reset: port 0 first
    pulse_reset();
    drive(0, 1'b0, 8'h01, 16'h0);
    drive(1, 1'b0, 8'h02, 16'h0);
    push(0, 1'b1, 16'h1111);
    push(1, 1'b1, 16'h2222);
    n = 0; t0 = -1; t1 = -1;
    while ((t0 < 0 || t1 < 0) && n < 12) begin
      tick();
      n++;
      if (ack0 && t0 < 0) begin t0 = n; req0 = 1'b0; end
      if (ack1 && t1 < 0) begin t1 = n; req1 = 1'b0; end
    end
    chk("tie_ack0_cycle", t0, 2);
    chk("tie_ack1_cycle", t1, 5);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Continuous contention: ports alternate, one ack every 3 cycles
    drive(0, 1'b0, 8'h01, 16'h0);
    drive(1, 1'b0, 8'h02, 16'h0);
    push(0, 1'b1, 16'h1111);
    push(1, 1'b1, 16'h2222);
    push(0, 1'b1, 16'h1111);
    push(1, 1'b1, 16'h2222);
    n = 0; nack = 0;
    while (nack < 4 && n < 20) begin
      tick();
      n++;
      if (ack0 || ack1) begin at[nack] = n; nack++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ack_count", nack, 4);
    chk("cont_first", at[0], 2);
    for (int i = 1; i < 4; i++) chk("cont_spacing", at[i] - at[i-1], 3);
    chk("cont_last_gnt", {31'd0, gnt_id}, 1);
    tick();
    tick();
    chk("cont_idle_busy", {31'd0, busy}, 0);

    // Reset during ACCESS: write to 0x10 must not commit
    drive(1, 1'b1, 8'h10, 16'hDEAD);
    tick();
    chk("midacc_cs_before", {31'd0, mem_cs_}, 0);
    rst = 1'b1;
    #1;
    chk("midacc_cs_async", {31'd0, mem_cs_}, 1);
    chk("midacc_busy", {31'd0, busy}, 0);
    req1 = 1'b0;
    tick();
    rst = 1'b0;
    exp_rd0 = 16'h0;
    exp_rd1 = 16'h0;
    tick(); tick(); tick();
    do_txn(1, 1'b0, 8'h10, 16'h0, 16'hBEEF);

    // Reset during DONE: ack drops immediately
    drive(0, 1'b0, 8'h05, 16'h0);
    push(0, 1'b1, 16'hA5A5);
    tick();
    tick();
    chk("middone_ack_before", {31'd0, ack0}, 1);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("middone_ack_async", {31'd0, ack0}, 0);
    tick();
    rst = 1'b0;
    exp_rd0 = 16'h0;
    tick();

    // Requester drops req during ACCESS: still completes and acks once
    drive(0, 1'b0, 8'h7F, 16'h0);
    push(0, 1'b1, 16'h003C);
    tick();
    chk("drop_busy_access", {31'd0, busy}, 1);
    req0 = 1'b0;
    tick();
    chk("drop_ack0", {31'd0, ack0}, 1);
    tick();
    chk("drop_busy_after", {31'd0, busy}, 0);
    chk("drop_ack0_low", {31'd0, ack0}, 0);
    tick();
    tick();

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
